// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM access arbiter: FSM state encoding,
// default bus widths and the watchdog counter sizing helper.
// No ports; imported by eeprom_rr_arb and eeprom_access_arb.
package eeprom_pkg;

    localparam int EEPROM_ADDR_W = 11;
    localparam int EEPROM_DATA_W = 8;

    // One engine transaction walks IDLE -> ISSUE -> WAIT_ACK -> DONE -> GAP.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_DONE     = 3'd3,
        ST_GAP      = 3'd4
    } arb_state_t;

    // Watchdog counter is at least 13 bits so the default 4096-cycle limit fits,
    // and grows if a larger limit is configured.
    function automatic int cnt_width(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        return (w > 13) ? w : 13;
    endfunction

endpackage

// File: rtl/eeprom_rr_arb.sv
// Combinational round-robin picker: first set request strictly after the
// last-granted index, wrapping. Ports: req_i (request vector), last_i (last
// winner) -> gnt_o (one-hot), idx_o (winner index), any_o (some request set).
module eeprom_rr_arb
    import eeprom_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDXW    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDXW-1:0]    idx_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] w_onehot;
    logic [IDXW-1:0]    w_idx;
    logic [IDXW-1:0]    w_cand;
    logic               w_found;

    // Scan starting one past the last winner so the last winner is checked
    // last; it can only win again when nobody else is asking.
    always_comb begin
        w_onehot = '0;
        w_idx    = '0;
        w_cand   = '0;
        w_found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = IDXW'((int'(last_i) + i) % NUM_REQ);
            if (!w_found && req_i[w_cand]) begin
                w_found          = 1'b1;
                w_idx            = w_cand;
                w_onehot[w_cand] = 1'b1;
            end
        end
    end

    assign gnt_o = w_onehot;
    assign idx_o = w_idx;
    assign any_o = w_found;

endmodule

// File: rtl/eeprom_access_arb.sv
// Round-robin arbiter sharing one serial-EEPROM engine among NUM_REQ requesters.
// Requester side: req_i/we_i/addr_i/wdata_i in, gnt_o/done_o/rdata_o/err_o out.
// Engine side: eng_wr_o/eng_rd_o/eng_addr_o/eng_wdata_o/eng_data_oe_o out,
// eng_rdata_i/eng_ack_i in. Optional ACK watchdog: define EEPROM_ARB_TIMEOUT_EN.
module eeprom_access_arb
    import eeprom_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = EEPROM_ADDR_W,
    parameter int DATA_W      = EEPROM_DATA_W,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        err_o,
    output logic                        eng_wr_o,
    output logic                        eng_rd_o,
    output logic [ADDR_W-1:0]           eng_addr_o,
    output logic [DATA_W-1:0]           eng_wdata_o,
    output logic                        eng_data_oe_o,
    input  logic [DATA_W-1:0]           eng_rdata_i,
    input  logic                        eng_ack_i
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;

    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [IDXW-1:0]    r_idx;
    logic [IDXW-1:0]    r_last;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_wr;
    logic               r_rd;
    logic               r_oe;

    logic [NUM_REQ-1:0] w_onehot;
    logic [IDXW-1:0]    w_idx;
    logic               w_any;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    logic               w_grant;
    logic               w_issue;
    logic               w_finish;
    logic               w_release;
    logic               w_tmo;

    eeprom_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr (
        .req_i  (req_i),
        .last_i (r_last),
        .gnt_o  (w_onehot),
        .idx_o  (w_idx),
        .any_o  (w_any)
    );

    // Mux out the winning requester's command fields for latching at grant.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (w_idx == IDXW'(n)) begin
                w_sel_we    = we_i[n];
                w_sel_addr  = addr_i[n*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata_i[n*DATA_W +: DATA_W];
            end
        end
    end

`ifdef EEPROM_ARB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Counts WAIT_ACK cycles; the TIMEOUT_CYC-th one without ACK aborts, so
    // the strobe is held for exactly TIMEOUT_CYC cycles.
    assign w_tmo = (r_state == ST_WAIT_ACK) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_finish && w_tmo && !eng_ack_i;
            if (r_state == ST_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT_ACK && !eng_ack_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYC != 0);
    assign err_o        = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // ACK wins over a same-cycle timeout.
                if (eng_ack_i || w_tmo) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_release   = 1'b1;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                // Strobes are already low; this cycle guarantees the engine sees
                // a deassertion before the next command.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_gnt   <= '0;
            r_done  <= '0;
            r_idx   <= '0;
            r_last  <= IDXW'(NUM_REQ - 1);
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_oe    <= 1'b0;
        end else begin
            r_done <= '0;
            if (w_grant) begin
                r_gnt   <= w_onehot;
                r_idx   <= w_idx;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                // Drive the data bus from ISSUE so it is settled before the strobe.
                r_oe    <= w_sel_we;
            end
            if (w_issue) begin
                r_wr <= r_we;
                r_rd <= ~r_we;
            end
            if (w_finish) begin
                r_wr    <= 1'b0;
                r_rd    <= 1'b0;
                r_oe    <= 1'b0;
                r_done  <= r_gnt;
                r_rdata <= (eng_ack_i && !r_we) ? eng_rdata_i : '0;
            end
            if (w_release) begin
                r_gnt  <= '0;
                r_last <= r_idx;
            end
        end
    end

    assign gnt_o         = r_gnt;
    assign done_o        = r_done;
    assign rdata_o       = r_rdata;
    assign eng_wr_o      = r_wr;
    assign eng_rd_o      = r_rd;
    assign eng_addr_o    = r_addr;
    assign eng_wdata_o   = r_wdata;
    assign eng_data_oe_o = r_oe;

endmodule
